// File: rtl/nx_node_control_mapped_pkg.sv
// Shared geometry, mesh command encodings and map/message layouts for the node controller.
// Pure declarations: no timing, no flow control.
package nx_node_control_mapped_pkg;

  localparam int TARGET_W  = 8;
  localparam int CMD_W     = 8;
  localparam int PAYLOAD_W = 24;
  localparam int VALID_W   = PAYLOAD_W / CMD_W;
  localparam int OP_W      = 4;
  localparam int REG_W     = 16;
  localparam int IO_W      = 4;
  localparam int SLOTS     = 32;
  localparam int INST_W    = OP_W + 3 * $clog2(REG_W) + 1 + $clog2(IO_W);
  localparam int FANOUT    = 2;
  localparam int TXQ_DEPTH = 8;

  localparam int IDX_W     = $clog2(IO_W);
  localparam int SLOT_W    = $clog2(SLOTS);
  // A single-entry map still needs one bit to carry the entry field.
  localparam int ENT_W     = (FANOUT > 1) ? $clog2(FANOUT) : 1;
  localparam int CMD_IDX_W = CMD_W - 3;
  localparam int MSG_W     = TARGET_W + CMD_W + PAYLOAD_W;

  typedef enum logic [2:0] {
    CMD_LOAD_INSTR = 3'd0,
    CMD_LAST_INSTR = 3'd1,
    CMD_BIT_VALUE  = 3'd2,
    CMD_OUT_MAP    = 3'd3
  } nx_command_t;

  // OUT_MAP payload, target in the least significant bits.
  typedef struct packed {
    logic                en;
    logic [IDX_W-1:0]    out_idx;
    logic [ENT_W-1:0]    entry;
    logic [IDX_W-1:0]    in_idx;
    logic [TARGET_W-1:0] target;
  } nx_out_map_t;

  typedef struct packed {
    logic                en;
    logic [IDX_W-1:0]    in_idx;
    logic [TARGET_W-1:0] target;
  } map_ent_t;

  typedef struct packed {
    logic [TARGET_W-1:0]  target;
    logic [CMD_W-1:0]     command;
    logic [PAYLOAD_W-1:0] payload;
  } tx_msg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [IO_W-1:0] mask);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = IO_W - 1; i >= 0; i--) begin
      if (mask[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/nx_node_control_mapped_if.sv
// Mesh rx/tx, core load and core output signals of the node controller; slave is the controller side.
// Handshakes: rx_complete/rx_ready, tx_valid/tx_ready; core loads are unqualified pulses.
interface nx_node_control_mapped_if;
  import nx_node_control_mapped_pkg::*;

  logic                  stall;
  logic [CMD_W-1:0]      rx_command;
  logic [PAYLOAD_W-1:0]  rx_payload;
  logic [VALID_W-1:0]    rx_valid;
  logic                  rx_complete;
  logic                  rx_ready;
  logic [INST_W-1:0]     load_instr;
  logic [SLOT_W-1:0]     load_slot;
  logic                  load_last;
  logic                  load_valid;
  logic                  in_value;
  logic [IDX_W-1:0]      in_index;
  logic                  in_valid;
  logic [IO_W-1:0]       out_values;
  logic [IO_W-1:0]       out_valids;
  logic [TARGET_W-1:0]   tx_target;
  logic [CMD_W-1:0]      tx_command;
  logic [PAYLOAD_W-1:0]  tx_payload;
  logic [VALID_W-1:0]    tx_valid;
  logic                  tx_ready;

  modport master (
    input  stall, rx_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid, tx_target, tx_command, tx_payload, tx_valid,
    output rx_command, rx_payload, rx_valid, rx_complete, out_values, out_valids, tx_ready
  );

  modport slave (
    output stall, rx_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid, tx_target, tx_command, tx_payload, tx_valid,
    input  rx_command, rx_payload, rx_valid, rx_complete, out_values, out_valids, tx_ready
  );

endinterface

// File: rtl/nx_node_control_mapped_fifo.sv
// Synchronous FIFO with full/empty/level; data visible at head the cycle after the push.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module nx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (level_o == '0);
  assign full_o    = (level_o == (AW + 1)'(DEPTH));
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/nx_node_control_mapped.sv
// Decodes mesh rx commands into core loads (1 cycle) and fans core output updates out to tx (2 cycles).
// tx backpressure fills the queue, then holds the scanner; stall holds the core while work is pending.
module nx_node_control_mapped
  import nx_node_control_mapped_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  nx_node_control_mapped_if.slave bus
);
  localparam int MAP_N  = IO_W * FANOUT;
  localparam int MAP_AW = (MAP_N > 1) ? $clog2(MAP_N) : 1;

  if ($bits(nx_out_map_t) > PAYLOAD_W) begin : g_map_fit_chk
    $error("OUT_MAP fields do not fit in PAYLOAD_W");
  end

  function automatic logic [MAP_AW-1:0] map_addr(input logic [IDX_W-1:0] o,
                                                 input logic [ENT_W-1:0] e);
    return MAP_AW'(int'(o) * FANOUT + ((FANOUT > 1) ? int'(e) : 0));
  endfunction

  logic                 rx_ready_q;
  logic [INST_W-1:0]    load_instr_q;
  logic [SLOT_W-1:0]    load_slot_q;
  logic                 load_last_q, load_valid_q;
  logic                 in_value_q, in_valid_q;
  logic [IDX_W-1:0]     in_index_q;
  map_ent_t             map_q [MAP_N];
  logic [IO_W-1:0]      pending_q, pending_d, value_q, clr_mask;
  scan_state_t          state_q, state_d;
  logic [IDX_W-1:0]     out_q, out_d;
  logic [ENT_W-1:0]     ent_q, ent_d;

  logic [2:0]           rx_cmd;
  logic [CMD_IDX_W-1:0] rx_idx;
  logic                 rx_fire;
  nx_out_map_t          map_wr;
  map_ent_t             cur_ent;
  logic                 last_ent, scan_adv, push, tx_pop;
  logic                 txq_full, txq_empty;
  logic [$clog2(TXQ_DEPTH):0] txq_level;
  tx_msg_t              push_msg, txq_head, tx_head;
  logic                 unused_ok;

  assign rx_cmd  = bus.rx_command[CMD_W-1 -: 3];
  assign rx_idx  = bus.rx_command[CMD_IDX_W-1:0];
  assign rx_fire = bus.rx_complete & rx_ready_q;
  assign map_wr  = bus.rx_payload[$bits(nx_out_map_t)-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_q   <= 1'b0;
      load_instr_q <= '0;
      load_slot_q  <= '0;
      load_last_q  <= 1'b0;
      load_valid_q <= 1'b0;
      in_value_q   <= 1'b0;
      in_index_q   <= '0;
      in_valid_q   <= 1'b0;
      pending_q    <= '0;
      value_q      <= '0;
      for (int i = 0; i < MAP_N; i++) map_q[i] <= '0;
    end else begin
      rx_ready_q   <= 1'b1;
      load_valid_q <= 1'b0;
      in_valid_q   <= 1'b0;
      if (rx_fire) begin
        case (rx_cmd)
          CMD_LOAD_INSTR, CMD_LAST_INSTR: begin
            load_instr_q <= bus.rx_payload[INST_W-1:0];
            load_slot_q  <= SLOT_W'(rx_idx);
            load_last_q  <= (rx_cmd == CMD_LAST_INSTR);
            load_valid_q <= 1'b1;
          end
          CMD_BIT_VALUE: begin
            in_value_q <= bus.rx_payload[0];
            in_index_q <= rx_idx[IDX_W-1:0];
            in_valid_q <= 1'b1;
          end
          CMD_OUT_MAP:
            map_q[map_addr(map_wr.out_idx, map_wr.entry)] <=
              '{en: map_wr.en, in_idx: map_wr.in_idx, target: map_wr.target};
          default: ;
        endcase
      end
      pending_q <= pending_d;
      for (int i = 0; i < IO_W; i++) begin
        if (bus.out_valids[i]) value_q[i] <= bus.out_values[i];
      end
    end
  end

  // Scanner: one map entry per cycle; a fresh strobe beats the clear of its own bit.
  assign cur_ent   = map_q[map_addr(out_q, ent_q)];
  assign last_ent  = (ent_q == ENT_W'(FANOUT - 1));
  assign tx_pop    = ~txq_empty & bus.tx_ready;
  assign scan_adv  = (state_q == ST_SCAN) && (!cur_ent.en || !txq_full || tx_pop);
  assign push      = scan_adv & cur_ent.en;
  assign clr_mask  = (scan_adv && last_ent) ? (IO_W'(1) << out_q) : '0;
  assign pending_d = (pending_q & ~clr_mask) | bus.out_valids;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      ent_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ent_q   <= ent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ent_d   = ent_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_d) begin
          state_d = ST_SCAN;
          out_d   = lowest_set(pending_d);
          ent_d   = '0;
        end
      end
      ST_SCAN: begin
        if (scan_adv) begin
          if (!last_ent) begin
            ent_d = ent_q + 1'b1;
          end else if (|pending_d) begin
            out_d = lowest_set(pending_d);
            ent_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_msg = '{target:  cur_ent.target,
                      command: {CMD_BIT_VALUE, CMD_IDX_W'(cur_ent.in_idx)},
                      payload: PAYLOAD_W'(value_q[out_q])};

  nx_fifo #(.WIDTH(MSG_W), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_msg),
    .pop_i      (tx_pop),
    .pop_dat_o  (txq_head),
    .full_o     (txq_full),
    .empty_o    (txq_empty),
    .level_o    (txq_level)
  );

  // Head storage is not reset, so mask it while the queue is empty.
  assign tx_head        = txq_empty ? '0 : txq_head;
  assign bus.tx_target  = tx_head.target;
  assign bus.tx_command = tx_head.command;
  assign bus.tx_payload = tx_head.payload;
  assign bus.tx_valid   = txq_empty ? '0 : VALID_W'(1);

  assign bus.stall      = (|pending_q) | (state_q == ST_SCAN) | txq_full;
  assign bus.rx_ready   = rx_ready_q;
  assign bus.load_instr = load_instr_q;
  assign bus.load_slot  = load_slot_q;
  assign bus.load_last  = load_last_q;
  assign bus.load_valid = load_valid_q;
  assign bus.in_value   = in_value_q;
  assign bus.in_index   = in_index_q;
  assign bus.in_valid   = in_valid_q;

  assign unused_ok = ^{bus.rx_valid, bus.rx_payload, txq_level};

endmodule
